// File: rtl/mem_bus_arbiter_pkg.sv
`timescale 1ns/1ps
// Shared state type, timeout constants and grant encodings for the
// two-master memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic [3:0]  WAIT_LIMIT = 4'd15;
  localparam logic [15:0] ERR_DATA   = 16'hFFFF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_DMA  = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter_wait_timer.sv
`timescale 1ns/1ps
// Wait-state counter for one memory access; expired flags the cycle in which
// the access has waited WAIT_LIMIT cycles and memory is still not ready.
module arb_wait_timer
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ready,
  output logic expired
);

  logic [3:0] count_reg;

  // start is held high outside a grant, so every access begins from zero.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      count_reg <= '0;
    end else if (!ready && (count_reg != WAIT_LIMIT)) begin
      count_reg <= count_reg + 4'd1;
    end
  end

  assign expired = (count_reg == WAIT_LIMIT) && !ready;

endmodule

// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// Arbitrates a single memory port between a CPU and a DMA master, with
// fair tie-breaking, per-access wait timeout and a sticky error flag.
module mem_bus_arbiter
  import mem_arb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mreq_n,
  input  logic        cpu_r_w_n,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_r_w_n,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        mem_req,
  output logic        mem_r_w_n,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        bus_err,
  input  logic        err_clr
);

  arb_state_t  state_reg, state_next;
  logic        last_dma_reg;
  logic        any_done_reg;
  logic        lat_rw_reg;
  logic [15:0] lat_addr_reg;
  logic [15:0] lat_wdata_reg;
  logic [15:0] cpu_rdata_reg;
  logic [15:0] dma_rdata_reg;
  logic        bus_err_reg;

  logic in_gnt;
  logic expired;
  logic finish;
  logic dma_turn;

  arb_wait_timer u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (!in_gnt),
    .ready   (mem_ready),
    .expired (expired)
  );

  assign in_gnt = (state_reg == GNT_CPU) || (state_reg == GNT_DMA);
  assign finish = in_gnt && (mem_ready || expired);
  // The CPU wins every tie until a CPU access has completed; after that the
  // master that was not served last wins.
  assign dma_turn = any_done_reg && !last_dma_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!cpu_mreq_n && dma_req) begin
          state_next = dma_turn ? GNT_DMA : GNT_CPU;
        end else if (!cpu_mreq_n) begin
          state_next = GNT_CPU;
        end else if (dma_req) begin
          state_next = GNT_DMA;
        end
      end
      GNT_CPU, GNT_DMA: begin
        if (mem_ready || expired) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_dma_reg  <= 1'b0;
      any_done_reg  <= 1'b0;
      lat_rw_reg    <= 1'b0;
      lat_addr_reg  <= '0;
      lat_wdata_reg <= '0;
      cpu_rdata_reg <= '0;
      dma_rdata_reg <= '0;
      bus_err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && (state_next == GNT_CPU)) begin
        lat_rw_reg    <= cpu_r_w_n;
        lat_addr_reg  <= cpu_addr;
        lat_wdata_reg <= cpu_wdata;
      end else if ((state_reg == IDLE) && (state_next == GNT_DMA)) begin
        lat_rw_reg    <= dma_r_w_n;
        lat_addr_reg  <= dma_addr;
        lat_wdata_reg <= dma_wdata;
      end
      if (finish) begin
        last_dma_reg <= (state_reg == GNT_DMA);
        any_done_reg <= 1'b1;
        if (!mem_ready) begin
          if (state_reg == GNT_DMA) dma_rdata_reg <= ERR_DATA;
          else                      cpu_rdata_reg <= ERR_DATA;
        end else if (lat_rw_reg) begin
          if (state_reg == GNT_DMA) dma_rdata_reg <= mem_rdata;
          else                      cpu_rdata_reg <= mem_rdata;
        end
      end
      // A timeout in the same cycle as err_clr leaves the flag set.
      if (finish && !mem_ready) begin
        bus_err_reg <= 1'b1;
      end else if (err_clr) begin
        bus_err_reg <= 1'b0;
      end
    end
  end

  always_comb begin
    grant = GRANT_NONE;
    if (state_reg == GNT_CPU) grant = GRANT_CPU;
    if (state_reg == GNT_DMA) grant = GRANT_DMA;
  end

  assign mem_req   = in_gnt;
  assign mem_r_w_n = lat_rw_reg;
  assign mem_addr  = lat_addr_reg;
  assign mem_wdata = lat_wdata_reg;
  assign cpu_ack   = (state_reg == DONE) && !last_dma_reg;
  assign dma_ack   = (state_reg == DONE) && last_dma_reg;
  assign cpu_rdata = cpu_rdata_reg;
  assign dma_rdata = dma_rdata_reg;
  assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_bus_arbiter: directed accesses push expected acks
// and memory-side accesses; monitors pop and compare as the DUT responds.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_mreq_n = 1'b1;
  logic        cpu_r_w_n = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        dma_req = 1'b0;
  logic        dma_r_w_n = 1'b1;
  logic [15:0] dma_addr = '0;
  logic [15:0] dma_wdata = '0;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic        mem_req;
  logic        mem_r_w_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  grant;
  logic        bus_err;
  logic        err_clr;
  logic        manual_clr = 1'b0;
  logic        auto_clr = 1'b0;

  assign err_clr = manual_clr | auto_clr;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_mreq_n(cpu_mreq_n), .cpu_r_w_n(cpu_r_w_n), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_r_w_n(dma_r_w_n), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_r_w_n(mem_r_w_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .bus_err(bus_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        dma;
    logic [15:0] rdata;
    logic        err;
  } ack_exp_t;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  ack_exp_t aq[$];
  mem_exp_t mq[$];
  mem_exp_t cur;
  logic     in_access = 1'b0;
  int       total = 0;
  int       bad = 0;
  int       acks_seen = 0;

  // Memory responder configuration, set by the stimulus process.
  int          resp_delay = 0;
  int          resp_cnt = 0;
  logic        resp_fixed = 1'b1;
  logic [15:0] resp_data = '0;
  logic        clr_on_timeout = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, req);
    end
  endtask

  // Memory model: ready in the GNT cycle whose index equals resp_delay.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ready = (resp_cnt == resp_delay);
      mem_rdata = mem_ready ? (resp_fixed ? resp_data : {mem_addr[7:0], mem_addr[15:8]})
                            : 16'hDEAD;
      auto_clr  = clr_on_timeout && (resp_cnt == 15);
      resp_cnt++;
    end else begin
      mem_ready = 1'b0;
      auto_clr  = 1'b0;
      resp_cnt  = 0;
    end
  end

  // Memory-side monitor: one expected entry per access, checked every GNT cycle.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_access) begin
        in_access = 1'b1;
        if (mq.size() == 0) begin
          chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
          cur = '0;
        end else begin
          cur = mq.pop_front();
          $display("access grant=%b rw=%b addr=%h wdata=%h", grant, mem_r_w_n, mem_addr, mem_wdata);
        end
      end
      chk("mem_grant", {30'd0, grant}, {30'd0, cur.gnt});
      chk("mem_r_w_n", {31'd0, mem_r_w_n}, {31'd0, cur.rw});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, cur.addr});
      chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, cur.wdata});
    end else begin
      in_access = 1'b0;
    end
  end

  // Ack monitor: every ack pulse must match the next expected completion.
  always @(negedge clk) begin
    ack_exp_t e;
    if (cpu_ack || dma_ack) begin
      acks_seen++;
      if (aq.size() == 0) begin
        chk("unexpected_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
      end else begin
        e = aq.pop_front();
        $display("ack cpu=%b dma=%b cpu_rdata=%h dma_rdata=%h bus_err=%b",
                 cpu_ack, dma_ack, cpu_rdata, dma_rdata, bus_err);
        chk("ack_both", {31'd0, cpu_ack & dma_ack}, 32'd0);
        chk("ack_dma", {31'd0, dma_ack}, {31'd0, e.dma});
        chk("ack_rdata", {16'd0, (e.dma ? dma_rdata : cpu_rdata)}, {16'd0, e.rdata});
        chk("ack_bus_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end
  end

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (acks_seen < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ack_arrived", acks_seen, (acks_seen < target) ? target : acks_seen);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic start_cpu(input logic rw, input logic [15:0] a, input logic [15:0] d);
    cpu_r_w_n = rw; cpu_addr = a; cpu_wdata = d; cpu_mreq_n = 1'b0;
    mq.push_back('{2'b01, rw, a, d});
  endtask

  task automatic start_dma(input logic rw, input logic [15:0] a, input logic [15:0] d);
    dma_r_w_n = rw; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    mq.push_back('{2'b10, rw, a, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_acks", {30'd0, cpu_ack, dma_ack}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    chk("rst_mem_out", {mem_addr, mem_wdata}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // CPU read 0x1234, ready after 2 cycles; inputs change during the grant.
    @(posedge clk); #1;
    resp_delay = 2; resp_fixed = 1'b1; resp_data = 16'hBEEF;
    start_cpu(1'b1, 16'h1234, 16'h0000);
    aq.push_back('{1'b0, 16'hBEEF, 1'b0});
    @(posedge clk); #1;
    cpu_addr = 16'hFFFF; cpu_r_w_n = 1'b0; cpu_wdata = 16'h7777;
    wait_acks(1, 40);
    @(posedge clk); #1;
    cpu_mreq_n = 1'b1;
    chk("s1_dma_rdata", {16'd0, dma_rdata}, 32'd0);

    // CPU write at minimum latency; cpu_rdata keeps the earlier read value.
    @(posedge clk); #1;
    resp_delay = 0;
    start_cpu(1'b0, 16'h0042, 16'h9999);
    aq.push_back('{1'b0, 16'hBEEF, 1'b0});
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    chk("min_latency_ack", {31'd0, cpu_ack}, 32'd1);
    wait_acks(2, 10);
    @(posedge clk); #1;
    cpu_mreq_n = 1'b1;

    // Three ties with both requests held: CPU, DMA, CPU.
    do_reset();
    resp_delay = 1; resp_fixed = 1'b0;
    cpu_r_w_n = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h0000; cpu_mreq_n = 1'b0;
    dma_r_w_n = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h0000; dma_req = 1'b1;
    mq.push_back('{2'b01, 1'b1, 16'h0100, 16'h0000});
    mq.push_back('{2'b10, 1'b1, 16'h0200, 16'h0000});
    mq.push_back('{2'b01, 1'b1, 16'h0100, 16'h0000});
    aq.push_back('{1'b0, 16'h0001, 1'b0});
    aq.push_back('{1'b1, 16'h0002, 1'b0});
    aq.push_back('{1'b0, 16'h0001, 1'b0});
    wait_acks(5, 60);
    @(posedge clk); #1;
    cpu_mreq_n = 1'b1; dma_req = 1'b0;

    // DMA write with silent memory: timeout, then err_clr.
    @(posedge clk); #1;
    resp_delay = 99;
    start_dma(1'b0, 16'h00A0, 16'h5555);
    aq.push_back('{1'b1, 16'hFFFF, 1'b1});
    wait_acks(6, 40);
    chk("to_mem_req", {31'd0, mem_req}, 32'd0);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    @(posedge clk); #1;
    dma_req = 1'b0; manual_clr = 1'b1;
    @(posedge clk); #1;
    manual_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", {31'd0, bus_err}, 32'd0);

    // Ready on the last allowed wait cycle counts as success.
    @(posedge clk); #1;
    resp_delay = 15; resp_fixed = 1'b1; resp_data = 16'h1357;
    start_dma(1'b1, 16'h0F0F, 16'h0000);
    aq.push_back('{1'b1, 16'h1357, 1'b0});
    wait_acks(7, 40);
    @(posedge clk); #1;
    dma_req = 1'b0;
    @(negedge clk);
    chk("edge_bus_err", {31'd0, bus_err}, 32'd0);

    // Timeout coinciding with err_clr: the error still sets.
    @(posedge clk); #1;
    resp_delay = 99; clr_on_timeout = 1'b1;
    start_cpu(1'b1, 16'h2222, 16'h0000);
    aq.push_back('{1'b0, 16'hFFFF, 1'b1});
    wait_acks(8, 40);
    @(posedge clk); #1;
    cpu_mreq_n = 1'b1; clr_on_timeout = 1'b0;
    @(negedge clk);
    chk("set_wins_sticky", {31'd0, bus_err}, 32'd1);

    // Reset in the middle of a CPU grant: no ack, bus released.
    @(posedge clk); #1;
    start_cpu(1'b1, 16'h3333, 16'h0000);
    for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
    chk("mid_mem_req_seen", {31'd0, mem_req}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; cpu_mreq_n = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_grant", {30'd0, grant}, 32'd0);
    chk("mid_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    chk("mid_bus_err", {31'd0, bus_err}, 32'd0);
    chk("mid_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    repeat (20) @(negedge clk);
    chk("mid_no_ack", acks_seen, 8);

    chk("ack_queue_empty", aq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous active-high reset: clk (rising edge), reset (synchronous, active-high).
REQ-002 The block SHALL provide these ports, listed as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cpu_mreq_n  in  1  controller memory request, active-low level, held until cpu_ack
- cpu_r_w_n  in  1  controller direction: 1 = read, 0 = write
- cpu_addr  in  16  controller address
- cpu_wdata  in  16  controller write data
- cpu_ack  out  1  one-cycle completion pulse to the controller ACK input
- cpu_rdata  out  16  read data for the controller
- dma_req  in  1  DMA/IO request, active-high level, held until dma_ack
- dma_r_w_n  in  1  DMA direction
- dma_addr  in  16  DMA address
- dma_wdata  in  16  DMA write data
- dma_ack  out  1  one-cycle completion pulse to DMA
- dma_rdata  out  16  read data for DMA
- mem_req  out  1  memory access strobe
- mem_r_w_n  out  1  memory direction
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- grant  out  2  current owner: 00 none, 01 cpu, 10 dma
- bus_err  out  1  sticky timeout flag
- err_clr  in  1  clears bus_err

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, GNT_CPU, GNT_DMA, DONE.
REQ-004 IDLE SHALL move to GNT_CPU at the next edge if only ~cpu_mreq_n is sampled, and to GNT_DMA if only dma_req is sampled.
REQ-005 On a tie in IDLE, the block SHALL grant the requester not served last, tracked by flag last_dma (reset 0, so the CPU wins the first tie).
REQ-006 On the edge entering GNT_x, the block SHALL latch that requester's r_w_n, addr and wdata, and drive them on mem_* until the grant ends; the block SHALL ignore requester input changes during the grant.
REQ-007 mem_req SHALL be 1 exactly while in GNT_CPU or GNT_DMA; grant SHALL be 01 or 10 in those states and 00 otherwise.
REQ-008 When mem_ready=1 is sampled in GNT_x, the block SHALL:
- capture mem_rdata into x_rdata (reads only; writes leave x_rdata unchanged);
- update last_dma;
- go to DONE.
REQ-009 In DONE, the block SHALL assert the served requester's ack for exactly one cycle, then return to IDLE.
- Minimum latency: request sampled at edge N, mem_ready high in cycle N+1, ack high in cycle N+2.
REQ-010 The block SHALL ignore mem_ready outside GNT states, and SHALL never grant a request sampled during DONE.
REQ-011 A 4-bit wait counter SHALL clear on GNT entry and increment on each GNT cycle with mem_ready=0.
REQ-012 When the wait counter reaches 15 with mem_ready still 0, the block SHALL abort the access:
- go to DONE;
- set x_rdata = 16'hFFFF;
- set bus_err = 1;
- ack the requester normally.
REQ-013 mem_ready=1 in the same cycle the count reaches 15 SHALL count as success.
REQ-014 err_clr SHALL clear bus_err; if a set and err_clr occur in the same cycle, set SHALL win.
REQ-015 x_rdata SHALL hold its value until the next completion for that requester.

Reset
REQ-016 When reset is sampled high, the block SHALL set: state = IDLE, mem_req = 0, cpu_ack = dma_ack = 0, grant = 00, bus_err = 0, last_dma = 0, wait counter = 0, and all 16-bit outputs = 0.
REQ-017 A reset during GNT or DONE SHALL abort the transfer with no ack emitted; mem_req SHALL be low from the cycle after the reset edge.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state typedef, WAIT_LIMIT = 4'd15, ERR_DATA = 16'hFFFF and the grant encodings.
REQ-019 The wait counter and timeout compare SHALL be sub-module arb_wait_timer (inputs: clk, reset, start, ready; output: expired); everything else SHALL be flat.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- CPU read 0x1234, mem_ready after 2 cycles returning 0xBEEF -> one cpu_ack pulse, cpu_rdata = 0xBEEF, dma_ack never asserted.
- CPU and DMA requests asserted in the same cycle, held, three times -> grant order CPU, DMA, CPU; each ack exactly one cycle.
- DMA write 0x00A0/0x5555, memory silent for 16 cycles -> mem_req drops, dma_ack pulses, dma_rdata = 0xFFFF, bus_err = 1; err_clr -> bus_err = 0.
- mem_ready arrives on the 15th wait cycle -> success: rdata = memory data, bus_err stays 0.
- Reset asserted mid-GNT_CPU -> mem_req low the next cycle, no cpu_ack, grant = 00.
- err_clr asserted together with a timeout -> bus_err = 1.
